sd_frame_rw_sched: RTL and testbench
====================================

// Module: sd_frame_rw_sched
// PURPOSE
//  Sequences whole-frame SD-card transfers for the VGA capture/playback path. Accepts
//  capture (write) and playback (read) frame requests, arbitrates between them, and
//  drives the SD controller's sector start/address handshake one sector at a time.
//  Stores frames in a ring of NUM_SLOTS slots; playback reads the newest complete slot.
//  Sits between the capture/display logic and the SD read/write controllers.
// PARAMETERS
//  SEC_NUM     1200   sectors per frame (640*480*16b/512B)
//  BASE_ADDR   2000   first sector of slot 0
//  NUM_SLOTS   4      frame slots in the ring (2..16)
//  TIMEOUT_CYC 2^24   max cycles a busy phase may last (used only with SD_SCHED_TIMEOUT_EN)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous reset, active low
//  sd_init_done in   1   SD card initialised (level)
//  cap_req      in   1   request: write one frame (1-cycle pulse)
//  play_req     in   1   request: read one frame (1-cycle pulse)
//  wr_busy      in   1   SD write controller busy
//  rd_busy      in   1   SD read controller busy
//  wr_start_en  out  1   start one sector write (1-cycle pulse)
//  wr_sec_addr  out  32  write sector address
//  rd_start_en  out  1   start one sector read (1-cycle pulse)
//  rd_sec_addr  out  32  read sector address
//  cap_done     out  1   frame write complete (1-cycle pulse)
//  play_done    out  1   frame read complete (1-cycle pulse)
//  sched_busy   out  1   a frame transfer is in progress
//  err          out  1   sticky transfer timeout (always 0 without SD_SCHED_TIMEOUT_EN)
// BEHAVIOUR
//  Clocking/reset: one clock domain; rst_n is asynchronous, active low.
//  Reset values: all pulse outputs, sched_busy, err, slot/sector counters = 0;
//   wr_sec_addr = rd_sec_addr = BASE_ADDR; valid_slots = 0.
//  Input registering:
//   - wr_busy and rd_busy are each registered twice.
//   - Sector done = falling edge of the registered pair (d1 & ~d0).
//  Requests: cap_req/play_req set pending flags, which clear when that transfer enters
//   its START state. A repeat pulse while pending is absorbed.
//  FSM states: IDLE, WR_START, WR_WAIT, RD_START, RD_WAIT.
//   IDLE:
//    - Requires sd_init_done=1. Until then, pending flags hold and nothing is issued.
//    - Pending write beats pending read (both pending, or same-cycle pulses).
//    - Pending read with valid_slots=0: flag cleared, play_done pulsed, no sectors read.
//   WR_START:
//    - wr_sec_addr = BASE_ADDR + wr_slot*SEC_NUM + sec_cnt.
//    - wr_start_en=1 for 1 cycle, then go to WR_WAIT.
//   WR_WAIT, on sector done:
//    - sec_cnt+1.
//    - If sec_cnt==SEC_NUM-1: sec_cnt=0; rd_slot=wr_slot; wr_slot=(wr_slot+1)%NUM_SLOTS;
//      valid_slots=1; cap_done pulse; go to IDLE.
//    - Else go to WR_START (next start pulse 1 cycle after the done edge).
//   RD_START/RD_WAIT: mirror of the write states using rd_slot, rd_busy, rd_start_en,
//    rd_sec_addr and play_done. rd_slot is not changed by a read.
//  Arithmetic: address sums in 32 bits; sec_cnt 11 bits; slot index 4 bits.
//  Latency: IDLE to first start pulse = 2 cycles. Sector done to next start = 1 cycle.
//  sched_busy = 1 in any state other than IDLE.
//  A busy edge on the channel not currently active is ignored.
//  sd_init_done falling mid-transfer: finish the current sector, then go to IDLE.
//   sec_cnt resets to 0 and the slot is not advanced. The request is not re-queued.
//  Reset asserted mid-transfer: everything returns to reset values immediately.
// CONFIGURATION
//  SD_SCHED_TIMEOUT_EN defined:
//   - A counter runs in WR_WAIT/RD_WAIT and reloads on each sector done.
//   - Reaching TIMEOUT_CYC: err=1 (sticky until reset); go to IDLE.
//   - sec_cnt=0, no done pulse, slot not advanced.
//  Not defined: no counter; err is tied to 0; WAIT states wait indefinitely.
// TESTING
//  1 Reset, init_done=1, cap_req; model busy 20 cycles/sector -> 1200 wr_start_en pulses,
//    addrs 2000..3199, one cap_done, wr_slot=1.
//  2 Same-cycle cap_req+play_req after one capture -> write of slot 1 (3200..4399) runs
//    first; then read of slot 1 (3200..4399); play_done after cap_done.
//  3 play_req with no frame stored -> play_done in 2 cycles, zero rd_start_en.
//  4 Five captures with NUM_SLOTS=4 -> 5th frame written at 2000..3199 (wrap);
//    a read afterwards also reads 2000.
//  5 cap_req while init_done=0 -> nothing issued; raise init_done -> write starts 2 cycles later.
//  6 TIMEOUT_EN, TIMEOUT_CYC=100, hold wr_busy=1 -> err=1 at cycle 100 of WR_WAIT, IDLE,
//    no cap_done; without the macro the FSM stays in WR_WAIT.

Source files
------------

// File: rtl/sd_frame_rw_sched_if.sv
// sd_frame_rw_sched_if
//   Bundles the request/response and SD-controller handshake signals of the
//   frame scheduler.
//   master : the scheduler (drives start pulses, addresses, done/busy/err)
//   slave  : the surrounding capture/display logic and SD controllers
//
// Handshake semantics: cap_req/play_req are single-cycle request pulses that
// are latched internally, so no ready is returned; the matching cap_done /
// play_done pulse closes the request. wr_start_en/rd_start_en are single-cycle
// pulses with the sector address stable on the same cycle; the SD controller
// acknowledges completion of that sector by dropping wr_busy/rd_busy.
interface sd_frame_rw_sched_if;
  logic        sd_init_done;
  logic        cap_req;
  logic        play_req;
  logic        wr_busy;
  logic        rd_busy;
  logic        wr_start_en;
  logic [31:0] wr_sec_addr;
  logic        rd_start_en;
  logic [31:0] rd_sec_addr;
  logic        cap_done;
  logic        play_done;
  logic        sched_busy;
  logic        err;

  modport master (
    input  sd_init_done, cap_req, play_req, wr_busy, rd_busy,
    output wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr,
           cap_done, play_done, sched_busy, err
  );

  modport slave (
    output sd_init_done, cap_req, play_req, wr_busy, rd_busy,
    input  wr_start_en, wr_sec_addr, rd_start_en, rd_sec_addr,
           cap_done, play_done, sched_busy, err
  );
endinterface

// File: rtl/sd_frame_rw_sched.sv
// sd_frame_rw_sched
//   Sequences whole-frame SD transfers for the VGA capture/playback path.
//   Capture (write) and playback (read) requests are arbitrated, then the SD
//   controller is driven one sector at a time. Frames live in a ring of
//   NUM_SLOTS slots; playback reads the newest completely written slot.
// Ports
//   clk       : system clock
//   rst_n     : asynchronous reset, active low
//   bus       : sd_frame_rw_sched_if.master (requests, SD handshake, status)
//   dbg_state : current FSM state (0 IDLE, 1 WR_START, 2 WR_WAIT,
//               3 RD_START, 4 RD_WAIT)
// Optional feature
//   SD_SCHED_TIMEOUT_EN : when defined, a WAIT phase longer than TIMEOUT_CYC
//   cycles aborts the transfer and sets the sticky err flag. When undefined
//   err is tied low and WAIT states wait indefinitely.
module sd_frame_rw_sched #(
  parameter int unsigned SEC_NUM     = 1200,
  parameter int unsigned BASE_ADDR   = 2000,
  parameter int unsigned NUM_SLOTS   = 4,
  parameter int unsigned TIMEOUT_CYC = 32'd1 << 24
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sd_frame_rw_sched_if.master  bus,
  output logic [2:0]           dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_START = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_START = 3'd3,
    S_RD_WAIT  = 3'd4
  } state_t;

  localparam logic [10:0] SEC_LAST  = 11'(SEC_NUM - 1);
  localparam logic [3:0]  SLOT_LAST = 4'(NUM_SLOTS - 1);

  state_t      state_q, state_d;
  logic        cap_pend_q, cap_pend_d;
  logic        play_pend_q, play_pend_d;
  logic        init_q, init_d;
  logic        wr_busy_s0_q, wr_busy_s0_d, wr_busy_s1_q, wr_busy_s1_d;
  logic        rd_busy_s0_q, rd_busy_s0_d, rd_busy_s1_q, rd_busy_s1_d;
  logic [10:0] sec_cnt_q, sec_cnt_d;
  logic [3:0]  wr_slot_q, wr_slot_d;
  logic [3:0]  rd_slot_q, rd_slot_d;
  logic        valid_q, valid_d;
  logic [31:0] wr_addr_q, wr_addr_d;
  logic [31:0] rd_addr_q, rd_addr_d;
  logic        cap_done_q, cap_done_d;
  logic        play_done_q, play_done_d;
  logic        wr_done, rd_done;
  logic        tmo_hit;

  // A sector has finished when the registered busy falls (older stage high,
  // newer stage low).
  assign wr_done = wr_busy_s1_q & ~wr_busy_s0_q;
  assign rd_done = rd_busy_s1_q & ~rd_busy_s0_q;

`ifdef SD_SCHED_TIMEOUT_EN
  logic [31:0] tmo_cnt_q, tmo_cnt_d;
  logic        err_q, err_d;
  logic        in_wait;

  assign in_wait = (state_q == S_WR_WAIT) || (state_q == S_RD_WAIT);
  assign tmo_hit = in_wait && (tmo_cnt_q == TIMEOUT_CYC - 32'd1);

  always_comb begin
    tmo_cnt_d = 32'd0;
    err_d     = err_q | tmo_hit;
    // Count only while waiting; every completed sector restarts the window.
    if (in_wait && !((state_q == S_WR_WAIT) ? wr_done : rd_done)) begin
      tmo_cnt_d = tmo_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_cnt_q <= 32'd0;
      err_q     <= 1'b0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
      err_q     <= err_d;
    end
  end

  assign bus.err = err_q;
`else
  assign tmo_hit = 1'b0;
  assign bus.err = 1'b0;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cap_pend_q   <= 1'b0;
      play_pend_q  <= 1'b0;
      init_q       <= 1'b0;
      wr_busy_s0_q <= 1'b0;
      wr_busy_s1_q <= 1'b0;
      rd_busy_s0_q <= 1'b0;
      rd_busy_s1_q <= 1'b0;
      sec_cnt_q    <= 11'd0;
      wr_slot_q    <= 4'd0;
      rd_slot_q    <= 4'd0;
      valid_q      <= 1'b0;
      wr_addr_q    <= BASE_ADDR;
      rd_addr_q    <= BASE_ADDR;
      cap_done_q   <= 1'b0;
      play_done_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_pend_q   <= cap_pend_d;
      play_pend_q  <= play_pend_d;
      init_q       <= init_d;
      wr_busy_s0_q <= wr_busy_s0_d;
      wr_busy_s1_q <= wr_busy_s1_d;
      rd_busy_s0_q <= rd_busy_s0_d;
      rd_busy_s1_q <= rd_busy_s1_d;
      sec_cnt_q    <= sec_cnt_d;
      wr_slot_q    <= wr_slot_d;
      rd_slot_q    <= rd_slot_d;
      valid_q      <= valid_d;
      wr_addr_q    <= wr_addr_d;
      rd_addr_q    <= rd_addr_d;
      cap_done_q   <= cap_done_d;
      play_done_q  <= play_done_d;
    end
  end

  // Next-state logic. sd_init_done is sampled once so that a level change
  // takes effect with the same two-cycle latency as a request pulse.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (init_q && cap_pend_q) begin
          state_d = S_WR_START;
        end else if (init_q && play_pend_q && valid_q) begin
          state_d = S_RD_START;
        end
      end
      S_WR_START: state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (tmo_hit) begin
          state_d = S_IDLE;
        end else if (wr_done) begin
          state_d = (sec_cnt_q == SEC_LAST || !init_q) ? S_IDLE : S_WR_START;
        end
      end
      S_RD_START: state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (tmo_hit) begin
          state_d = S_IDLE;
        end else if (rd_done) begin
          state_d = (sec_cnt_q == SEC_LAST || !init_q) ? S_IDLE : S_RD_START;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    init_d       = bus.sd_init_done;
    wr_busy_s0_d = bus.wr_busy;
    wr_busy_s1_d = wr_busy_s0_q;
    rd_busy_s0_d = bus.rd_busy;
    rd_busy_s1_d = rd_busy_s0_q;
    // A pulse arriving on the cycle its flag is consumed is absorbed.
    cap_pend_d   = cap_pend_q | bus.cap_req;
    play_pend_d  = play_pend_q | bus.play_req;
    sec_cnt_d    = sec_cnt_q;
    wr_slot_d    = wr_slot_q;
    rd_slot_d    = rd_slot_q;
    valid_d      = valid_q;
    wr_addr_d    = wr_addr_q;
    rd_addr_d    = rd_addr_q;
    cap_done_d   = 1'b0;
    play_done_d  = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (init_q) begin
          if (cap_pend_q) begin
            cap_pend_d = 1'b0;
          end else if (play_pend_q) begin
            play_pend_d = 1'b0;
            // Nothing stored yet: answer the request without touching the card.
            if (!valid_q) play_done_d = 1'b1;
          end
        end
      end
      S_WR_WAIT: begin
        if (tmo_hit) begin
          sec_cnt_d = 11'd0;
        end else if (wr_done) begin
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d  = 11'd0;
            rd_slot_d  = wr_slot_q;
            wr_slot_d  = (wr_slot_q == SLOT_LAST) ? 4'd0 : wr_slot_q + 4'd1;
            valid_d    = 1'b1;
            cap_done_d = 1'b1;
          end else if (!init_q) begin
            sec_cnt_d = 11'd0;
          end else begin
            sec_cnt_d = sec_cnt_q + 11'd1;
          end
        end
      end
      S_RD_WAIT: begin
        if (tmo_hit) begin
          sec_cnt_d = 11'd0;
        end else if (rd_done) begin
          if (sec_cnt_q == SEC_LAST) begin
            sec_cnt_d   = 11'd0;
            play_done_d = 1'b1;
          end else if (!init_q) begin
            sec_cnt_d = 11'd0;
          end else begin
            sec_cnt_d = sec_cnt_q + 11'd1;
          end
        end
      end
      default: ;
    endcase

    // Load the address on entry to START so it is valid with the start pulse.
    if (state_d == S_WR_START) begin
      wr_addr_d = BASE_ADDR + 32'(wr_slot_d) * SEC_NUM + 32'(sec_cnt_d);
    end
    if (state_d == S_RD_START) begin
      rd_addr_d = BASE_ADDR + 32'(rd_slot_d) * SEC_NUM + 32'(sec_cnt_d);
    end
  end

  // Outputs.
  always_comb begin
    bus.wr_start_en = (state_q == S_WR_START);
    bus.rd_start_en = (state_q == S_RD_START);
    bus.wr_sec_addr = wr_addr_q;
    bus.rd_sec_addr = rd_addr_q;
    bus.cap_done    = cap_done_q;
    bus.play_done   = play_done_q;
    bus.sched_busy  = (state_q != S_IDLE);
    dbg_state       = state_q;
  end

endmodule

// File: tb/tb_sd_frame_rw_sched.sv
module tb_sd_frame_rw_sched;
  localparam int SEC  = 1200;
  localparam int BASE = 2000;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;

  sd_frame_rw_sched_if bus ();

  sd_frame_rw_sched #(
    .SEC_NUM(SEC), .BASE_ADDR(BASE), .NUM_SLOTS(4), .TIMEOUT_CYC(100)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int bsy_len = 20;
  int wr_start_cnt = 0, rd_start_cnt = 0;
  int cap_cnt = 0, play_cnt = 0;
  int cap_cyc = 0, play_cyc = 0;
  logic [31:0] wr_exp_q[$];
  logic [31:0] rd_exp_q[$];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // ---------------- SD controller models ----------------
  initial begin
    bus.wr_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.wr_start_en) begin
        bus.wr_busy = 1'b1;
        repeat (bsy_len) @(posedge clk);
        #1 bus.wr_busy = 1'b0;
      end
    end
  end

  initial begin
    bus.rd_busy = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.rd_start_en) begin
        bus.rd_busy = 1'b1;
        repeat (bsy_len) @(posedge clk);
        #1 bus.rd_busy = 1'b0;
      end
    end
  end

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [31:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.wr_start_en) begin
          wr_start_cnt++;
          checks++;
          if (wr_exp_q.size() == 0) begin
            failures++;
            $display("FAIL wr_start_unexpected addr=%0d expected no start", bus.wr_sec_addr);
          end else begin
            exp = wr_exp_q.pop_front();
            if (bus.wr_sec_addr !== exp) begin
              failures++;
              $display("FAIL wr_sec_addr got=%0d exp=%0d", bus.wr_sec_addr, exp);
            end
          end
        end
        if (bus.rd_start_en) begin
          rd_start_cnt++;
          checks++;
          if (rd_exp_q.size() == 0) begin
            failures++;
            $display("FAIL rd_start_unexpected addr=%0d expected no start", bus.rd_sec_addr);
          end else begin
            exp = rd_exp_q.pop_front();
            if (bus.rd_sec_addr !== exp) begin
              failures++;
              $display("FAIL rd_sec_addr got=%0d exp=%0d", bus.rd_sec_addr, exp);
            end
          end
        end
        if (bus.cap_done) begin
          cap_cnt++;
          cap_cyc = cyc;
        end
        if (bus.play_done) begin
          play_cnt++;
          play_cyc = cyc;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_frame(input bit is_wr, input int slot);
    for (int s = 0; s < SEC; s++) begin
      if (is_wr) wr_exp_q.push_back(32'(BASE + slot * SEC + s));
      else       rd_exp_q.push_back(32'(BASE + slot * SEC + s));
    end
  endtask

  // Returns 1 cycle-tick (#1) after the posedge that samples the pulse.
  task automatic req(input bit cap, input bit play);
    @(negedge clk);
    bus.cap_req  = cap;
    bus.play_req = play;
    @(posedge clk); #1;
    bus.cap_req  = 1'b0;
    bus.play_req = 1'b0;
  endtask

  task automatic wait_done(input bit is_play, input int target, input int budget, output bit ok);
    int b;
    b = budget;
    while (((is_play ? play_cnt : cap_cnt) < target) && b > 0) begin
      @(posedge clk); #1;
      b--;
    end
    @(negedge clk);
    ok = ((is_play ? play_cnt : cap_cnt) >= target);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    do_reset();
    checks++;
    if (bus.sched_busy !== 1'b0 || bus.err !== 1'b0 || bus.wr_start_en !== 1'b0 ||
        bus.rd_start_en !== 1'b0 || bus.cap_done !== 1'b0 || bus.play_done !== 1'b0) begin
      failures++;
      $display("FAIL reset_flags busy=%b err=%b ws=%b rs=%b cd=%b pd=%b exp all 0",
               bus.sched_busy, bus.err, bus.wr_start_en, bus.rd_start_en, bus.cap_done, bus.play_done);
    end
    checks++;
    if (bus.wr_sec_addr !== 32'(BASE) || bus.rd_sec_addr !== 32'(BASE)) begin
      failures++;
      $display("FAIL reset_addr wr=%0d rd=%0d exp=%0d", bus.wr_sec_addr, bus.rd_sec_addr, BASE);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      failures++;
      $display("FAIL reset_state got=%0d exp=0", dbg_state);
    end
  endtask

  task automatic test_one_frame();
    bit ok;
    int c0;
    bsy_len = 20;
    c0 = cap_cnt;
    push_frame(1'b1, 0);
    req(1'b1, 1'b0);
    checks++;
    if (bus.wr_start_en !== 1'b0 || bus.sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL latency_early start=%b busy=%b exp 0 0", bus.wr_start_en, bus.sched_busy);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.wr_start_en !== 1'b1 || bus.sched_busy !== 1'b1) begin
      failures++;
      $display("FAIL latency_first start=%b busy=%b exp 1 1", bus.wr_start_en, bus.sched_busy);
    end
    wait_done(1'b0, c0 + 1, 30000, ok);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL one_frame_timeout cap_done_count=%0d exp=%0d", cap_cnt, c0 + 1);
    end
    checks++;
    if (wr_exp_q.size() != 0 || wr_start_cnt != SEC) begin
      failures++;
      $display("FAIL one_frame_sectors left=%0d starts=%0d exp left 0 starts %0d",
               wr_exp_q.size(), wr_start_cnt, SEC);
    end
    checks++;
    if (bus.sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL one_frame_idle busy=%b exp 0", bus.sched_busy);
    end
  endtask

  task automatic test_same_cycle();
    bit ok;
    int c0, p0;
    bsy_len = 1;
    c0 = cap_cnt;
    p0 = play_cnt;
    push_frame(1'b1, 1);
    push_frame(1'b0, 1);
    req(1'b1, 1'b1);
    wait_done(1'b1, p0 + 1, 15000, ok);
    checks++;
    if (!ok || cap_cnt != c0 + 1) begin
      failures++;
      $display("FAIL same_cycle_done cap=%0d play=%0d exp cap %0d play %0d",
               cap_cnt, play_cnt, c0 + 1, p0 + 1);
    end
    checks++;
    if (!(cap_cyc < play_cyc)) begin
      failures++;
      $display("FAIL same_cycle_order cap_cyc=%0d play_cyc=%0d exp cap first", cap_cyc, play_cyc);
    end
    checks++;
    if (wr_exp_q.size() != 0 || rd_exp_q.size() != 0) begin
      failures++;
      $display("FAIL same_cycle_left wr=%0d rd=%0d exp 0 0", wr_exp_q.size(), rd_exp_q.size());
    end
  endtask

  task automatic test_empty_play();
    int r0, p0;
    do_reset();
    r0 = rd_start_cnt;
    p0 = play_cnt;
    req(1'b0, 1'b1);
    checks++;
    if (bus.play_done !== 1'b0) begin
      failures++;
      $display("FAIL empty_play_early play_done=%b exp 0", bus.play_done);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.play_done !== 1'b1) begin
      failures++;
      $display("FAIL empty_play_done play_done=%b exp 1", bus.play_done);
    end
    repeat (10) @(posedge clk);
    @(negedge clk);
    checks++;
    if (rd_start_cnt != r0 || play_cnt != p0 + 1 || bus.sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL empty_play_quiet rd_starts=%0d plays=%0d busy=%b exp %0d %0d 0",
               rd_start_cnt, play_cnt, bus.sched_busy, r0, p0 + 1);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    int c0, p0;
    bsy_len = 1;
    for (int f = 0; f < 5; f++) begin
      c0 = cap_cnt;
      push_frame(1'b1, f % 4);
      req(1'b1, 1'b0);
      wait_done(1'b0, c0 + 1, 5000, ok);
      checks++;
      if (!ok || wr_exp_q.size() != 0) begin
        failures++;
        $display("FAIL wrap_frame%0d done=%0d left=%0d exp done 1 left 0", f, ok, wr_exp_q.size());
      end
    end
    p0 = play_cnt;
    push_frame(1'b0, 0);
    req(1'b0, 1'b1);
    wait_done(1'b1, p0 + 1, 5000, ok);
    checks++;
    if (!ok || rd_exp_q.size() != 0) begin
      failures++;
      $display("FAIL wrap_read done=%0d left=%0d exp done 1 left 0", ok, rd_exp_q.size());
    end
  endtask

  task automatic test_init_gate();
    bit ok;
    int w0, c0, b;
    bsy_len = 1;
    bus.sd_init_done = 1'b0;
    w0 = wr_start_cnt;
    c0 = cap_cnt;
    push_frame(1'b1, 1);
    req(1'b1, 1'b0);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_start_cnt != w0 || bus.sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL init_gate_hold starts=%0d busy=%b exp %0d 0", wr_start_cnt, bus.sched_busy, w0);
    end
    bus.sd_init_done = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.wr_start_en !== 1'b0) begin
      failures++;
      $display("FAIL init_gate_early start=%b exp 0", bus.wr_start_en);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.wr_start_en !== 1'b1 || bus.wr_sec_addr !== 32'(BASE + SEC)) begin
      failures++;
      $display("FAIL init_gate_start start=%b addr=%0d exp 1 %0d", bus.wr_start_en, bus.wr_sec_addr, BASE + SEC);
    end
    // Drop init mid-frame: the sector in flight finishes, then the FSM idles.
    b = 200;
    while (wr_start_cnt < w0 + 5 && b > 0) begin
      @(negedge clk);
      b--;
    end
    bus.sd_init_done = 1'b0;
    b = 200;
    while (bus.sched_busy === 1'b1 && b > 0) begin
      @(negedge clk);
      b--;
    end
    checks++;
    if (bus.sched_busy !== 1'b0 || cap_cnt != c0) begin
      failures++;
      $display("FAIL init_drop busy=%b caps=%0d exp 0 %0d", bus.sched_busy, cap_cnt, c0);
    end
    wr_exp_q.delete();
    // Re-issued capture restarts the same slot from sector 0.
    bus.sd_init_done = 1'b1;
    push_frame(1'b1, 1);
    req(1'b1, 1'b0);
    wait_done(1'b0, c0 + 1, 5000, ok);
    checks++;
    if (!ok || wr_exp_q.size() != 0) begin
      failures++;
      $display("FAIL init_recapture done=%0d left=%0d exp 1 0", ok, wr_exp_q.size());
    end
  endtask

  task automatic test_timeout();
    int w0, c0;
    bsy_len = 100000;
    w0 = wr_start_cnt;
    c0 = cap_cnt;
    wr_exp_q.push_back(32'(BASE + 2 * SEC));
    req(1'b1, 1'b0);
    repeat (150) @(posedge clk);
    @(negedge clk);
    checks++;
    if (wr_start_cnt != w0 + 1 || cap_cnt != c0) begin
      failures++;
      $display("FAIL stuck_starts starts=%0d caps=%0d exp %0d %0d", wr_start_cnt, cap_cnt, w0 + 1, c0);
    end
`ifdef SD_SCHED_TIMEOUT_EN
    checks++;
    if (bus.err !== 1'b1 || bus.sched_busy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_err err=%b busy=%b exp 1 0", bus.err, bus.sched_busy);
    end
`else
    checks++;
    if (bus.err !== 1'b0 || bus.sched_busy !== 1'b1 || dbg_state !== 3'd2) begin
      failures++;
      $display("FAIL stuck_wait err=%b busy=%b state=%0d exp 0 1 2", bus.err, bus.sched_busy, dbg_state);
    end
`endif
    // Reset in the middle of a transfer clears everything at once.
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.sched_busy !== 1'b0 || bus.err !== 1'b0 || bus.wr_sec_addr !== 32'(BASE)) begin
      failures++;
      $display("FAIL reset_mid busy=%b err=%b addr=%0d exp 0 0 %0d", bus.sched_busy, bus.err, bus.wr_sec_addr, BASE);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- main ----------------
  initial begin
    rst_n = 1'b1;
    bus.sd_init_done = 1'b1;
    bus.cap_req = 1'b0;
    bus.play_req = 1'b0;
    test_reset();
    test_one_frame();
    test_same_cycle();
    test_empty_play();
    test_wrap();
    test_init_gate();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
